rr_daisy_arbiter: RTL and testbench

- Registered, parametrised N-requester arbiter; sequential successor to the combinational daisy-chain arbiter.
- Two modes:
  - fixed priority: index 0 highest, the same daisy-chain order as the existing arbiter.
  - round-robin: rotating priority pointer.
- A grant is held while its requester keeps req asserted, bounded by a hold limit for fairness.
- Sits between N bus masters and a shared resource; one-hot grant plus encoded owner id.

---
 rtl/rr_daisy_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_daisy_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_daisy_arbiter.sv
// rr_daisy_arbiter
//   Registered N-requester arbiter sitting between N bus masters and one
//   shared resource. Fixed-priority (index 0 highest) or round-robin
//   selection; an owner keeps the grant while it keeps requesting, but is
//   forced off after MAX_HOLD consecutive cycles if anyone else is waiting.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   req[0:N-1] request vector, req[0] = highest fixed priority
//   mode       0 = fixed priority, 1 = round-robin
//   gnt[0:N-1] registered one-hot grant, zero when idle
//   gnt_valid  |gnt
//   gnt_id     index of current owner, 0 when idle
module rr_daisy_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [0:N-1]    req,
  input  logic            mode,
  output logic [0:N-1]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q,   ptr_d;
  logic [HW-1:0]   hold_q,  hold_d;

  logic [0:N-1]    others;
  logic [ID_W:0]   sel_req, sel_oth;
  logic            do_grant;
  logic [ID_W-1:0] win;

  // Returns {found, index}. The scan runs backwards through the priority
  // order so the last hit written is the first in order.
  function automatic logic [ID_W:0] pick(input logic [0:N-1]    v,
                                         input logic            rr,
                                         input logic [ID_W-1:0] p);
    logic [ID_W:0] r;
    int            j;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = rr ? (int'(p) + i) % N : i;
      if (v[j[ID_W-1:0]]) r = {1'b1, j[ID_W-1:0]};
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    win      = '0;

    // Everyone except the current owner; only meaningful in S_GRANT.
    others          = req;
    others[owner_q] = 1'b0;
    sel_req = pick(req,    mode, ptr_q);
    sel_oth = pick(others, mode, ptr_q);

    case (state_q)
      S_IDLE: begin
        if (sel_req[ID_W]) begin
          do_grant = 1'b1;
          win      = sel_req[ID_W-1:0];
        end
      end
      S_GRANT: begin
        if (!req[owner_q]) begin
          // Release: hand straight to the next requester, no idle bubble.
          if (sel_req[ID_W]) begin
            do_grant = 1'b1;
            win      = sel_req[ID_W-1:0];
          end else begin
            state_d = S_IDLE;
            hold_d  = '0;
          end
        end else if (MAX_HOLD == 0 || hold_q < HOLD_MAX) begin
          if (MAX_HOLD != 0) hold_d = hold_q + 1'b1;
        end else if (sel_oth[ID_W]) begin
          // Hold limit reached with others waiting: forced handover.
          do_grant = 1'b1;
          win      = sel_oth[ID_W-1:0];
        end
        // else: sole requester keeps the grant, hold stays saturated.
      end
      default: state_d = S_IDLE;
    endcase

    if (do_grant) begin
      state_d = S_GRANT;
      owner_d = win;
      hold_d  = HW'(1);
      ptr_d   = ID_W'((int'(win) + 1) % N);
    end
  end

  // Outputs decode from registered state only, so req never reaches them
  // combinationally.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    if (state_q == S_GRANT) begin
      gnt[owner_q] = 1'b1;
      gnt_valid    = 1'b1;
      gnt_id       = owner_q;
    end
  end

endmodule

// File: tb/tb_rr_daisy_arbiter.sv
// Bench for rr_daisy_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=0)
// share one stimulus stream and are each compared every cycle against a
// behavioural reference model, plus directed checks and fairness bounds.
module tb_rr_daisy_arbiter;

  logic       clk = 1'b0;
  logic       reset, mode;
  logic [0:7] req;
  logic [0:7] gnt_a, gnt_b;
  logic       v_a, v_b;
  logic [2:0] id_a, id_b;

  always #5 clk = ~clk;

  rr_daisy_arbiter #(.N(8), .MAX_HOLD(4)) u_a (
    .clk(clk), .reset(reset), .req(req), .mode(mode),
    .gnt(gnt_a), .gnt_valid(v_a), .gnt_id(id_a));

  rr_daisy_arbiter #(.N(8), .MAX_HOLD(0)) u_b (
    .clk(clk), .reset(reset), .req(req), .mode(mode),
    .gnt(gnt_b), .gnt_valid(v_b), .gnt_id(id_b));

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 -> u_a, 1 -> u_b
  int m_own[2];
  int m_ptr[2];
  int m_hold[2];

  logic [0:7] req_s;
  logic       mode_s, rst_s;
  int         run_own = -1;
  int         run_len = 0;
  int         waitc[8];
  int         max_wait = 0;
  bit         track_wait = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // First requester in priority order: index order, or rotating from p.
  function automatic int sel(input logic [0:7] v, input logic md, input int p);
    int j;
    for (int o = 0; o < 8; o++) begin
      j = md ? (p + o) % 8 : o;
      if (v[j[2:0]]) return j;
    end
    return -1;
  endfunction

  task automatic mstep(input int d);
    int w, mh;
    logic [0:7] oth;
    mh = (d == 0) ? 4 : 0;
    w  = -1;
    if (rst_s) begin
      m_own[d] = -1; m_ptr[d] = 0; m_hold[d] = 0;
    end else begin
      if (m_own[d] < 0) begin
        w = sel(req_s, mode_s, m_ptr[d]);
      end else if (!req_s[m_own[d][2:0]]) begin
        w = sel(req_s, mode_s, m_ptr[d]);
        if (w < 0) begin m_own[d] = -1; m_hold[d] = 0; end
      end else if (mh == 0 || m_hold[d] < mh) begin
        if (mh > 0) m_hold[d]++;
      end else begin
        oth = req_s;
        oth[m_own[d][2:0]] = 1'b0;
        w = sel(oth, mode_s, m_ptr[d]);
      end
      if (w >= 0) begin
        m_own[d] = w; m_hold[d] = 1; m_ptr[d] = (w + 1) % 8;
      end
    end
  endtask

  task automatic cmp(input int d, input logic [0:7] g, input logic v, input logic [2:0] id);
    logic [0:7] e;
    e = '0;
    if (m_own[d] >= 0) e[m_own[d][2:0]] = 1'b1;
    chk($sformatf("gnt%0d", d),   32'(g),  32'(e));
    chk($sformatf("valid%0d", d), 32'(v),  32'(m_own[d] >= 0));
    chk($sformatf("id%0d", d),    32'(id), 32'((m_own[d] >= 0) ? m_own[d] : 0));
    chk($sformatf("onehot%0d", d), 32'($countones(g) <= 1), 32'd1);
    chk($sformatf("gnt_req%0d", d), 32'(g & ~req_s), 32'd0);
    chk($sformatf("valid_or%0d", d), 32'(v), 32'(|g));
  endtask

  task automatic tick();
    logic [0:7] oth;
    @(posedge clk);
    req_s = req; mode_s = mode; rst_s = reset;
    mstep(0);
    mstep(1);
    #1;
    cmp(0, gnt_a, v_a, id_a);
    cmp(1, gnt_b, v_b, id_b);
    // consecutive cycles one owner holds while others were requesting
    oth = req_s;
    if (v_a) oth[id_a] = 1'b0;
    if (!rst_s && v_a && oth != 0) begin
      if (int'(id_a) == run_own) run_len++;
      else begin run_own = int'(id_a); run_len = 1; end
      chk("hold_bound", 32'(run_len <= 4), 32'd1);
    end else begin
      run_own = -1; run_len = 0;
    end
    if (track_wait) begin
      for (int i = 0; i < 8; i++) begin
        if (req_s[i] && !(v_a && int'(id_a) == i)) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; mode = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; mode = 1'b0;
    do_reset();
    chk("rst_gnt",   32'(gnt_a), 32'd0);
    chk("rst_valid", 32'(v_a),   32'd0);
    chk("rst_id",    32'(id_a),  32'd0);

    // fixed-priority sweep, each value from idle
    for (int v = 0; v < 256; v++) begin
      req = 8'(v); tick();
      req = '0;    tick();
    end
    chk("idle_valid", 32'(v_a), 32'd0);
    req = 8'b00101100; tick();
    chk("ex_gnt", 32'(gnt_a), 32'h20);
    chk("ex_id",  32'(id_a),  32'd2);

    // round-robin, everyone requesting: 4 cycles each in order
    do_reset();
    mode = 1'b1; req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      tick();
      chk("rr_own", 32'(id_a), 32'((k / 4) % 8));
    end

    // sole requester holds past the limit, then same-cycle handover
    do_reset();
    mode = 1'b1; req = 8'b00000100;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("solo_id", 32'(id_a), 32'd5);
      chk("solo_v",  32'(v_a),  32'd1);
    end
    req = 8'b00100000; tick();
    chk("hand_id", 32'(id_a), 32'd2);
    chk("hand_v",  32'(v_a),  32'd1);

    // unlimited hold instance keeps owner 6 despite higher priority req
    do_reset();
    mode = 1'b0; req = 8'b00000010;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) req[0] = 1'b1;
      tick();
      chk("mh0_own", 32'(id_b), 32'd6);
    end
    req = 8'b10000000; tick();
    chk("mh0_next", 32'(id_b), 32'd0);
    chk("mh0_v",    32'(v_b),  32'd1);

    // reset in the middle of a grant
    do_reset();
    req = 8'b00010000; tick();
    chk("g3_id", 32'(id_a), 32'd3);
    req = 8'hFF; reset = 1'b1; tick();
    chk("mid_rst_gnt", 32'(gnt_a), 32'd0);
    chk("mid_rst_id",  32'(id_a),  32'd0);
    reset = 1'b0; mode = 1'b1; tick();
    chk("post_rst_id", 32'(id_a), 32'd0);

    // random mixed phase
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(5) == 0) req[i] = ~req[i];
      if ($urandom_range(49) == 0) mode = ~mode;
      reset = ($urandom_range(199) == 0);
      tick();
    end

    // random round-robin phase with starvation tracking
    reset = 1'b0; mode = 1'b1;
    for (int i = 0; i < 8; i++) waitc[i] = 0;
    track_wait = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      tick();
    end
    chk("starve_max", 32'(max_wait <= 32), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
